noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Wormhole output-port arbiter that consumes NUM_IN input FIFOs, which are show-ahead and pop on rd_en.
- Round-robin grants one packet at a time and holds the grant from HEAD flit through TAIL flit, so packets never interleave.
- Drives one registered valid/ready output link toward the next router or NI.
- Sits directly downstream of the router input FIFOs.

Parameters:
- NUM_IN, 4, number of input FIFOs arbitrated (2..8).
- DATA_WIDTH, 16, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] hold the flit type.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_empty  in  NUM_IN  per-input FIFO empty flag.
- in_data  in  NUM_IN*DATA_WIDTH  per-input FIFO head flit (show-ahead); input i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_rd_en  out  NUM_IN  per-input pop strobe; one-hot or zero.
- out_valid  out  1  output flit valid.
- out_data  out  DATA_WIDTH  output flit.
- out_ready  in  1  downstream accepts the flit when out_valid & out_ready.
- locked  out  1  a packet is in progress.
- grant_idx  out  $clog2(NUM_IN)  input currently or last granted.
- proto_err  out  NUM_IN  sticky per-input error flag.

Behaviour:
- Reset: synchronous, all outputs/state cleared. out_valid=0, out_data=0, in_rd_en=0, locked=0, proto_err=0, grant_idx=NUM_IN-1 (so input 0 has first priority).
- Flit types: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, SINGLE=2'b11.
- slot_free = !out_valid | out_ready. No read occurs unless slot_free.
- Unlocked, slot_free:
  - Candidates are inputs with !in_empty whose head type is HEAD or SINGLE.
  - Search order starts at grant_idx+1 mod NUM_IN; the first candidate wins.
  - in_rd_en[win]=1 combinationally in the same cycle; grant_idx<=win.
  - locked<=1 if the flit is HEAD; locked stays 0 for SINGLE.
- Locked, slot_free: if !in_empty[grant_idx], pop it. If the popped flit is TAIL, locked<=0.
  - A HEAD or SINGLE flit arriving while locked is forwarded, sets proto_err[grant_idx], and does not change the lock.
- Unlocked error case: an input with !in_empty whose head is BODY or TAIL is not a candidate, sets proto_err[i], and is never popped. That input stays blocked until reset.
- Output register: on pop, out_data<=popped flit and out_valid<=1 (latency 1 cycle from pop).
  - Else if out_ready, out_valid<=0; out_data holds its value.
- Throughput: one flit per cycle while out_ready=1.
- Backpressure: with out_valid & !out_ready, out_valid/out_data stay stable and in_rd_en=0.
- Empty mid-packet: the lock is held, no pop, and other inputs stay starved until the TAIL is popped.
- Same-cycle TAIL pop: only one pop per cycle, so re-arbitration starts the next cycle. grant_idx already equals the TAIL's input, so that input gets lowest priority.
- Reset mid-packet: lock dropped, and any flit sitting in the output register is discarded. Partial packets in the FIFOs are not flushed; the block flags them via proto_err when their BODY/TAIL flits reach the head.
- in_rd_en is combinational from in_empty, in_data, out_ready and state; no combinational path from in_* to out_*.

Decomposition:
- noc_pkg (shared):
  - flit_type_e enum.
  - FLIT_TYPE_W=2.
  - function flit_type(flit) returning the top two bits.
  - Reused by FIFO benches and the NI.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: gnt_valid, gnt_idx. Purely combinational rotate-priority.
- Top holds the lock FSM (UNLOCKED / LOCKED), the output register and the error flags.

Test Plan (NUM_IN=4, DATA_WIDTH=16, out_ready=1 unless noted):
1. After reset, input 0 holds SINGLE 0xC001 -> in_rd_en=4'b0001 in cycle n; out_valid=1, out_data=0xC001 in cycle n+1; locked stays 0; grant_idx=0.
2. Input 1 packet 0x8011,0x0012,0x4013 and input 2 SINGLE 0xC021, all present -> output order 0x8011,0x0012,0x4013,0xC021 on consecutive cycles; locked=1 during the first three pops only.
3. All 4 inputs each hold two SINGLE flits 0xC0i0,0xC0i1 -> output order 0xC000,0xC010,0xC020,0xC030,0xC001,0xC011,0xC021,0xC031.
4. out_ready=0 for 5 cycles while input 3 has HEAD 0x8031 queued -> out_data=0x8031 held stable with out_valid=1 and no further in_rd_en. Body 0x0032 appears the cycle after out_ready rises.
5. Input 0 head is BODY 0x0005 while unlocked, input 1 has SINGLE 0xC015 -> proto_err=4'b0001; 0xC015 forwarded; in_rd_en[0] never asserts.
6. rst pulsed for 1 cycle after HEAD 0x8041 popped from input 0 (locked=1) -> next cycle locked=0, out_valid=0, grant_idx=3. Input 0's following BODY sets proto_err[0].

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: flit type encoding and a helper to pull the
// type field out of a flit of any supported width.
package noc_pkg;

  localparam int unsigned FLIT_TYPE_W = 2;
  localparam int unsigned FLIT_MAX_W  = 64;

  typedef enum logic [FLIT_TYPE_W-1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // Callers zero-extend the flit to FLIT_MAX_W and pass its real width.
  function automatic flit_type_e flit_type(input logic [FLIT_MAX_W-1:0] flit,
                                           input int unsigned            width);
    return flit_type_e'(flit[width-1 -: FLIT_TYPE_W]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts one past the
// last winner, so the last winner has the lowest priority.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(N);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = last;
    idx       = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// Wormhole output-port arbiter: round-robin packet grant held HEAD..TAIL,
// registered valid/ready output link and sticky per-input protocol errors.
module noc_output_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            in_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_rd_en,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic                         locked,
  output logic [$clog2(NUM_IN)-1:0]    grant_idx,
  output logic [NUM_IN-1:0]            proto_err
);

  localparam int unsigned IW = $clog2(NUM_IN);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  lock_state_e           state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_IN-1:0]     err_q, err_d;

  logic [DATA_WIDTH-1:0] flits [NUM_IN];
  flit_type_e            ftype [NUM_IN];
  logic [NUM_IN-1:0]     req;
  logic                  win_valid;
  logic [IW-1:0]         win_idx;
  logic [IW-1:0]         sel;
  logic                  slot_free;
  logic                  pop;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      flits[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      ftype[i] = flit_type(FLIT_MAX_W'(flits[i]), DATA_WIDTH);
      req[i]   = !in_empty[i] && (ftype[i] == FLIT_HEAD || ftype[i] == FLIT_SINGLE);
    end
  end

  rr_arbiter #(.N(NUM_IN)) u_rr (
    .req      (req),
    .last     (grant_q),
    .gnt_valid(win_valid),
    .gnt_idx  (win_idx)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign sel       = (state_q == LOCKED) ? grant_q : win_idx;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    err_d       = err_q;
    pop         = 1'b0;
    in_rd_en    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      UNLOCKED: begin
        // A mid-packet flit at an idle head can never be legally granted.
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          if (!in_empty[i] && !(ftype[i] == FLIT_HEAD || ftype[i] == FLIT_SINGLE))
            err_d[i] = 1'b1;
        end
        if (slot_free && win_valid) begin
          pop     = 1'b1;
          grant_d = win_idx;
          if (ftype[win_idx] == FLIT_HEAD) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (slot_free && !in_empty[grant_q]) begin
          pop = 1'b1;
          if (ftype[grant_q] == FLIT_TAIL) state_d = UNLOCKED;
          if (ftype[grant_q] == FLIT_HEAD || ftype[grant_q] == FLIT_SINGLE)
            err_d[grant_q] = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    if (pop && !rst) in_rd_en[sel] = 1'b1;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = flits[sel];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      grant_q     <= IW'(NUM_IN - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign locked    = (state_q == LOCKED);
  assign grant_idx = grant_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios plus
// randomized packet traffic checked against a packet-level round-robin model.
module tb_noc_output_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_rd_en;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic           locked;
  logic [1:0]     grant_idx;
  logic [N-1:0]   proto_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] fq [N][$];
  logic [W-1:0] got [$];
  logic         rd0_seen;

  always #5 clk = ~clk;

  noc_output_arbiter #(.NUM_IN(N), .DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_empty (in_empty),
    .in_data  (in_data),
    .in_rd_en (in_rd_en),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .locked   (locked),
    .grant_idx(grant_idx),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      in_empty[i]       = (fq[i].size() == 0);
      in_data[i*W +: W] = (fq[i].size() == 0) ? '0 : fq[i][0];
    end
  endtask

  task automatic settle();
    refresh();
    #1;
  endtask

  // One clock: sample settled signals, take the edge, model the FIFO pops.
  task automatic step();
    logic [N-1:0] rd;
    logic         v0, r0, rst0;
    logic [W-1:0] d0;
    rd   = in_rd_en;
    v0   = out_valid;
    r0   = out_ready;
    d0   = out_data;
    rst0 = rst;
    chk("rd_onehot0", 32'($onehot0(rd)), 32'd1);
    if (v0 && r0 && !rst0) got.push_back(d0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rd[i]) begin
        chk("pop_nonempty", 32'(fq[i].size() != 0), 32'd1);
        if (fq[i].size() != 0) void'(fq[i].pop_front());
        if (i == 0) rd0_seen = 1'b1;
      end
    end
    if (v0 && !r0 && !rst0) begin
      chk("stall_rd", 32'(rd), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(d0));
    end
    settle();
  endtask

  task automatic do_reset(input bit flush);
    rst       = 1'b1;
    out_ready = 1'b1;
    if (flush) for (int i = 0; i < N; i++) fq[i].delete();
    settle();
    step();
    rst = 1'b0;
    settle();
    got.delete();
  endtask

  logic [W-1:0] e2 [4];
  logic         lk2 [4];
  logic [W-1:0] mq [N][$];
  int           pl [N][$];
  logic [W-1:0] expq [$];

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in_empty  = '1;
    in_data   = '0;
    rd0_seen  = 1'b0;
    do_reset(1'b1);
    do_reset(1'b1);

    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd3);
    chk("rst_err", 32'(proto_err), 32'd0);
    chk("rst_rd", 32'(in_rd_en), 32'd0);

    // Test 1: lone SINGLE on input 0
    fq[0].push_back(16'hC001);
    settle();
    chk("t1_rd", 32'(in_rd_en), 32'b0001);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hC001);
    chk("t1_locked", 32'(locked), 32'd0);
    chk("t1_grant", 32'(grant_idx), 32'd0);
    step();
    chk("t1_accepted", 32'(got.size()), 32'd1);

    // Test 2: packet on input 1 is not interleaved with SINGLE on input 2
    do_reset(1'b1);
    fq[1].push_back(16'h8011); fq[1].push_back(16'h0012); fq[1].push_back(16'h4013);
    fq[2].push_back(16'hC021);
    e2  = '{16'h8011, 16'h0012, 16'h4013, 16'hC021};
    lk2 = '{1'b1, 1'b1, 1'b0, 1'b0};
    settle();
    chk("t2_rd_first", 32'(in_rd_en), 32'b0010);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data", 32'(out_data), 32'(e2[k]));
      chk("t2_locked", 32'(locked), 32'(lk2[k]));
    end
    step();

    // Test 3: two SINGLEs per input rotate fairly
    do_reset(1'b1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) fq[i].push_back(16'hC000 | 16'(i << 4) | 16'(j));
    settle();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t3_data", 32'(out_data), 32'(16'hC000 | 16'((k % 4) << 4) | 16'(k / 4)));
    end
    step();

    // Test 4: backpressure holds the HEAD stable
    do_reset(1'b1);
    fq[3].push_back(16'h8031); fq[3].push_back(16'h0032); fq[3].push_back(16'h4033);
    out_ready = 1'b0;
    settle();
    chk("t4_rd_head", 32'(in_rd_en), 32'b1000);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t4_valid", 32'(out_valid), 32'd1);
      chk("t4_data", 32'(out_data), 32'h8031);
      chk("t4_rd", 32'(in_rd_en), 32'd0);
      step();
    end
    out_ready = 1'b1;
    settle();
    chk("t4_rd_resume", 32'(in_rd_en), 32'b1000);
    step();
    chk("t4_body", 32'(out_data), 32'h0032);
    step();
    chk("t4_tail", 32'(out_data), 32'h4033);
    chk("t4_unlock", 32'(locked), 32'd0);
    step();

    // Test 5: stray BODY at an idle head is flagged and never popped
    do_reset(1'b1);
    fq[0].push_back(16'h0005);
    fq[1].push_back(16'hC015);
    settle();
    rd0_seen = 1'b0;
    chk("t5_rd", 32'(in_rd_en), 32'b0010);
    step();
    chk("t5_err", 32'(proto_err), 32'b0001);
    chk("t5_data", 32'(out_data), 32'hC015);
    for (int c = 0; c < 3; c++) step();
    chk("t5_rd0_never", 32'(rd0_seen), 32'd0);
    chk("t5_err_sticky", 32'(proto_err), 32'b0001);
    chk("t5_locked", 32'(locked), 32'd0);

    // Test 6: reset mid-packet leaves the FIFO remainder to be flagged
    do_reset(1'b1);
    fq[0].push_back(16'h8041); fq[0].push_back(16'h0042); fq[0].push_back(16'h4043);
    settle();
    step();
    chk("t6_locked", 32'(locked), 32'd1);
    chk("t6_grant", 32'(grant_idx), 32'd0);
    rst = 1'b1;
    settle();
    chk("t6_rd_in_rst", 32'(in_rd_en), 32'd0);
    step();
    rst = 1'b0;
    settle();
    chk("t6_locked_rst", 32'(locked), 32'd0);
    chk("t6_valid_rst", 32'(out_valid), 32'd0);
    chk("t6_grant_rst", 32'(grant_idx), 32'd3);
    chk("t6_rd_body", 32'(in_rd_en), 32'd0);
    step();
    chk("t6_err", 32'(proto_err), 32'b0001);
    chk("t6_rd_blocked", 32'(in_rd_en), 32'd0);

    // Randomized well-formed packets, all queued up front, random backpressure
    for (int round = 0; round < 3; round++) begin
      int ptr;
      bit found;
      do_reset(1'b1);
      expq.delete();
      for (int i = 0; i < N; i++) begin
        int npk;
        mq[i].delete();
        pl[i].delete();
        npk = $urandom_range(1, 4);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 4);
          pl[i].push_back(len);
          for (int f = 0; f < len; f++) begin
            logic [1:0]   t;
            logic [W-1:0] fl;
            if (len == 1)       t = 2'b11;
            else if (f == 0)    t = 2'b10;
            else if (f == len-1) t = 2'b01;
            else                t = 2'b00;
            fl = {t, 14'($urandom)};
            fq[i].push_back(fl);
            mq[i].push_back(fl);
          end
        end
      end
      ptr   = N - 1;
      found = 1'b1;
      while (found) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int idx;
          idx = (ptr + k) % N;
          if (!found && pl[idx].size() != 0) begin
            int len;
            found = 1'b1;
            len   = pl[idx].pop_front();
            for (int f = 0; f < len; f++) expq.push_back(mq[idx].pop_front());
            ptr = idx;
          end
        end
      end
      settle();
      for (int cyc = 0; cyc < 3000 && got.size() < expq.size(); cyc++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        #1;
        step();
      end
      chk("rand_count", 32'(got.size()), 32'(expq.size()));
      for (int k = 0; k < got.size() && k < expq.size(); k++)
        chk("rand_flit", 32'(got[k]), 32'(expq[k]));
      chk("rand_err", 32'(proto_err), 32'd0);
      chk("rand_locked", 32'(locked), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
